// File: rtl/clk_div_pkg.sv
// Shared helpers for the programmable clock divider: channel-index width,
// ratio clamping and high-phase length.
package clk_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Ratios below MIN_DIV cannot produce a valid low phase, so they saturate up.
  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  function automatic int unsigned hi_len(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, latched ratio, pending-ratio slot and
// registered clk_out/tick outputs. Ratio and run changes land on period edges.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  output logic             pending,
  output logic             clk_out,
  output logic             tick,
  output logic             active
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div_nxt;
  logic             wrap;
  logic             apply;
  logic             act_nxt;
  logic             clk_nxt;

  assign wrap    = (cnt == div - DIV_W'(1));
  assign apply   = pending && (!active || wrap);
  assign div_nxt = apply ? pend_div : div;

  // Idle or wrapping channels decide run/stop from the enable level; a running
  // channel otherwise always finishes its period.
  always_comb begin
    act_nxt = active;
    cnt_nxt = cnt + DIV_W'(1);
    if (!active || wrap) begin
      act_nxt = en;
      cnt_nxt = '0;
    end
  end

  assign clk_nxt = act_nxt &&
                   ({1'b0, cnt_nxt} < (DIV_W+1)'(hi_len(32'(div_nxt))));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div      <= DIV_W'(DEFAULT_DIV);
      pend_div <= DIV_W'(DEFAULT_DIV);
      pending  <= 1'b0;
      active   <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div     <= div_nxt;
      active  <= act_nxt;
      clk_out <= clk_nxt;
      tick    <= act_nxt && (cnt_nxt == '0);
      // load and apply are exclusive: load needs pending low, apply needs it high
      if (load) begin
        pend_div <= DIV_W'(clamp_div(32'(load_div)));
        pending  <= 1'b1;
      end else if (apply) begin
        pending  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_divider_prog.sv
// Multi-channel run-time programmable integer clock divider: config decode
// and handshake, plus NUM_CH independent divider channels.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     cfg_valid,
  input  logic [ch_w(NUM_CH)-1:0]  cfg_ch,
  input  logic [DIV_W-1:0]         cfg_div,
  output logic                     cfg_ready,
  output logic [NUM_CH-1:0]        clk_out,
  output logic [NUM_CH-1:0]        tick,
  output logic [NUM_CH-1:0]        active
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;

  // Indices with no channel behind them stay ready so stray writes drain.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = cfg_valid && (cfg_ch == CH_W'(g)) && !pending[g];

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in   (clk_in),
      .rst_n    (rst_n),
      .en       (ch_en[g]),
      .load     (load[g]),
      .load_div (cfg_div),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .active   (active[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: hand-computed waveforms per channel.
module tb_clk_divider_prog;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ch_en = '0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready;
  logic [3:0] clk_out;
  logic [3:0] tick;
  logic [3:0] active;

  int vectors = 0;
  int miscompares = 0;
  int hi;
  int lo;
  int coincide;
  int hc[4];

  always #5 clk_in = ~clk_in;

  clk_divider_prog #(
    .NUM_CH      (4),
    .DIV_W       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .active    (active)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    #1 check("cfg_ready_idle", 32'(cfg_ready), 32'(1'b1));
    cyc();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk_in);
    check("rst_clk_out", 32'(clk_out), 32'(4'h0));
    check("rst_tick", 32'(tick), 32'(4'h0));
    check("rst_active", 32'(active), 32'(4'h0));
    rst_n = 1'b1;
    cyc();
    check("post_rst_ready", 32'(cfg_ready), 32'(1'b1));
    check("post_rst_active", 32'(active), 32'(4'h0));
    check("post_rst_clk", 32'(clk_out), 32'(4'h0));

    // ch0 at default N=4: 1,1,0,0 with tick every 4th cycle
    ch_en[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) check("ch0_start_active", 32'(active[0]), 32'(1'b1));
      check("ch0_clk", 32'(clk_out[0]), 32'((k % 4) < 2));
      check("ch0_tick", 32'(tick[0]), 32'((k % 4) == 0));
    end

    // ch1 at N=4, write N=5 mid-period; new ratio only after the wrap
    ch_en[1] = 1'b1;
    cyc();
    check("ch1_cnt0_clk", 32'(clk_out[1]), 32'(1'b1));
    check("ch1_cnt0_tick", 32'(tick[1]), 32'(1'b1));
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    #1 check("ch1_ready_before", 32'(cfg_ready), 32'(1'b1));
    cyc();
    cfg_valid = 1'b0;
    check("ch1_cnt1_clk", 32'(clk_out[1]), 32'(1'b1));
    check("ch1_ready_pend1", 32'(cfg_ready), 32'(1'b0));
    cyc();
    check("ch1_cnt2_clk", 32'(clk_out[1]), 32'(1'b0));
    check("ch1_ready_pend2", 32'(cfg_ready), 32'(1'b0));
    cyc();
    check("ch1_cnt3_clk", 32'(clk_out[1]), 32'(1'b0));
    check("ch1_ready_pend3", 32'(cfg_ready), 32'(1'b0));
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 0) check("ch1_ready_after_wrap", 32'(cfg_ready), 32'(1'b1));
      check("ch1_n5_clk", 32'(clk_out[1]), 32'((k % 5) < 3));
      check("ch1_n5_tick", 32'(tick[1]), 32'((k % 5) == 0));
    end

    // ch2 at N=6, stop requested at cnt=1: period still completes in full
    cfg_write(2'd2, 8'd6);
    cyc();
    ch_en[2] = 1'b1;
    cyc();
    check("ch2_start_clk", 32'(clk_out[2]), 32'(1'b1));
    check("ch2_start_tick", 32'(tick[2]), 32'(1'b1));
    ch_en[2] = 1'b0;
    for (int k = 1; k < 6; k++) begin
      cyc();
      check("ch2_tail_clk", 32'(clk_out[2]), 32'(k < 3));
      check("ch2_tail_active", 32'(active[2]), 32'(1'b1));
      check("ch2_tail_tick", 32'(tick[2]), 32'(1'b0));
    end
    cyc();
    check("ch2_stop_active", 32'(active[2]), 32'(1'b0));
    check("ch2_stop_clk", 32'(clk_out[2]), 32'(1'b0));
    check("ch2_stop_tick", 32'(tick[2]), 32'(1'b0));
    repeat (3) begin
      cyc();
      check("ch2_idle_clk", 32'(clk_out[2]), 32'(1'b0));
    end

    // ch3: ratios 0 and 1 clamp to 2
    cfg_write(2'd3, 8'd0);
    cyc();
    ch_en[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("ch3_div0_clk", 32'(clk_out[3]), 32'((k % 2) == 0));
      check("ch3_div0_tick", 32'(tick[3]), 32'((k % 2) == 0));
    end
    ch_en[3] = 1'b0;
    cyc();
    check("ch3_div0_stop", 32'(active[3]), 32'(1'b0));
    cfg_write(2'd3, 8'd1);
    cyc();
    ch_en[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("ch3_div1_clk", 32'(clk_out[3]), 32'((k % 2) == 0));
      check("ch3_div1_tick", 32'(tick[3]), 32'((k % 2) == 0));
    end
    ch_en[3] = 1'b0;
    cyc();
    check("ch3_div1_stop", 32'(active[3]), 32'(1'b0));

    // ch3 at maximum ratio 255: 128 high then 127 low
    cfg_write(2'd3, 8'd255);
    cyc();
    ch_en[3] = 1'b1;
    hi = 0; lo = 0;
    for (int k = 0; k < 255; k++) begin
      cyc();
      if (clk_out[3]) hi++; else lo++;
      if (k == 127) check("ch3_max_last_hi", 32'(clk_out[3]), 32'(1'b1));
      if (k == 128) check("ch3_max_first_lo", 32'(clk_out[3]), 32'(1'b0));
    end
    check("ch3_max_hi_count", 32'(hi), 32'(128));
    check("ch3_max_lo_count", 32'(lo), 32'(127));
    cyc();
    check("ch3_max_period_tick", 32'(tick[3]), 32'(1'b1));

    // stop every channel and wait for all periods to finish
    ch_en = 4'h0;
    for (int w = 0; w < 300 && active != 4'h0; w++) cyc();
    check("all_stopped", 32'(active), 32'(4'h0));

    // all channels together at N=2,3,4,7: ticks realign every 84 cycles
    cfg_write(2'd0, 8'd2);
    cfg_write(2'd1, 8'd3);
    cfg_write(2'd2, 8'd4);
    cfg_write(2'd3, 8'd7);
    cyc();
    ch_en = 4'hF;
    cyc();
    check("multi_start_tick", 32'(tick), 32'(4'hF));
    check("multi_start_clk", 32'(clk_out), 32'(4'hF));
    for (int i = 0; i < 4; i++) hc[i] = 1;
    coincide = 0;
    for (int k = 1; k < 84; k++) begin
      cyc();
      for (int i = 0; i < 4; i++) if (clk_out[i]) hc[i]++;
      if (tick == 4'hF) coincide++;
    end
    check("multi_early_coincide", 32'(coincide), 32'(0));
    check("multi_hi_n2", 32'(hc[0]), 32'(42));
    check("multi_hi_n3", 32'(hc[1]), 32'(56));
    check("multi_hi_n4", 32'(hc[2]), 32'(42));
    check("multi_hi_n7", 32'(hc[3]), 32'(48));
    cyc();
    check("multi_tick_84", 32'(tick), 32'(4'hF));

    // async reset mid-period with an update pending on ch1
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd9;
    #1 check("rst_pend_ready", 32'(cfg_ready), 32'(1'b1));
    cyc();
    cfg_valid = 1'b0;
    check("rst_pend_set", 32'(cfg_ready), 32'(1'b0));
    #2;
    rst_n = 1'b0;
    ch_en = 4'h0;
    #1;
    check("async_rst_clk", 32'(clk_out), 32'(4'h0));
    check("async_rst_tick", 32'(tick), 32'(4'h0));
    check("async_rst_active", 32'(active), 32'(4'h0));
    check("async_rst_ready", 32'(cfg_ready), 32'(1'b1));
    @(negedge clk_in);
    rst_n = 1'b1;
    cyc();
    ch_en = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("post_rst_ch1_clk", 32'(clk_out[1]), 32'((k % 4) < 2));
      check("post_rst_ch1_tick", 32'(tick[1]), 32'((k % 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
